// File: rtl/nbank_batch_ctrl_pkg.sv
// Shared types for the N-bank batch controller: exec FSM state encoding and bank-count limit.
package nbank_batch_ctrl_pkg;

    localparam int MAX_NBANK = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DRAIN,
        RELEASE
    } bctl_state_t;

endpackage

// File: rtl/nbank_batch_ctrl_bank_tracker.sv
// Tracks which source banks hold a complete batch, plus the round-robin write/read pointers.
module nbank_batch_ctrl_bank_tracker
    import nbank_batch_ctrl_pkg::*;
#(
    parameter int NBANK = 2,
    parameter int BW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_i,
    input  logic          release_i,
    output logic [BW-1:0] wr_ptr_o,
    output logic [BW-1:0] rd_ptr_o,
    output logic [BW:0]   full_cnt_o,
    output logic          rd_full_o
);

    localparam logic [BW-1:0] LAST_IDX = BW'(NBANK - 1);

    logic [NBANK-1:0] full_q, full_d;
    logic [BW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BW:0]      cnt_q, cnt_d;

    // Fill and release never target the same bank: a fill needs a free bank at
    // wr_ptr, a release needs a full one at rd_ptr.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fill_i) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (release_i) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({fill_i, release_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_ptr_o   = wr_ptr_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign full_cnt_o = cnt_q;
    assign rd_full_o  = full_q[rd_ptr_q];

endmodule

// File: rtl/nbank_batch_ctrl.sv
// N-bank batch controller: fills source banks round-robin, sequences the core over each full
// bank, and drains results through the destination address counter.
module nbank_batch_ctrl
    import nbank_batch_ctrl_pkg::*;
#(
    parameter  int NBANK = 2,
    parameter  int AW    = 12,
    localparam int BW    = $clog2(NBANK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic          deltaw_i,
    input  logic          last_i,
    input  logic [AW-1:0] ss_i,
    input  logic [AW-1:0] ds_i,
    input  logic          src_valid_i,
    input  logic          src_last_i,
    output logic          src_ready_o,
    output logic          src_v_o,
    output logic [AW-1:0] src_a_o,
    output logic [BW-1:0] src_bank_o,
    output logic          s_init_o,
    input  logic          s_fin_i,
    output logic [BW-1:0] exec_bank_o,
    input  logic          dst_ready_i,
    output logic          dst_v_o,
    output logic [AW-1:0] dst_a_o,
    output logic          dst_valid_o,
    output logic          dst_acc_o,
    output logic [BW:0]   full_cnt_o,
    output logic          len_err_o
);

    if (NBANK < 2 || NBANK > MAX_NBANK) begin : g_bad_nbank
        $error("nbank_batch_ctrl: NBANK must be in 2..%0d", MAX_NBANK);
    end

    localparam logic [BW:0] NBANK_L = (BW + 1)'(NBANK);

    bctl_state_t   state_q, state_d;
    logic [AW-1:0] sa_q, sa_d, da_q, da_d;
    logic          len_err_q, len_err_d, dst_acc_q, dst_acc_d, dst_valid_q;
    logic          clr, beat, fill, rel, rd_full;
    logic [BW-1:0] wr_ptr, rd_ptr;
    logic [BW:0]   full_cnt;

    // run low behaves exactly like reset.
    assign clr         = rst | ~run_i;
    assign src_ready_o = ~clr & (full_cnt < NBANK_L);
    assign beat        = src_valid_i & src_ready_o;
    assign fill        = beat & ((sa_q == ss_i) | src_last_i);

    nbank_batch_ctrl_bank_tracker #(.NBANK(NBANK), .BW(BW)) u_tracker (
        .clk        (clk),
        .rst        (clr),
        .fill_i     (fill),
        .release_i  (rel),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .full_cnt_o (full_cnt),
        .rd_full_o  (rd_full)
    );

    always_comb begin
        sa_d      = sa_q;
        len_err_d = len_err_q;
        if (beat) sa_d = fill ? '0 : sa_q + 1'b1;
        if (beat && src_last_i && (sa_q != ss_i)) len_err_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        da_d      = da_q;
        dst_acc_d = dst_acc_q;
        s_init_o  = 1'b0;
        dst_v_o   = 1'b0;
        rel       = 1'b0;
        case (state_q)
            IDLE:  if (rd_full) state_d = START;
            START: begin
                s_init_o = 1'b1;
                state_d  = BUSY;
            end
            BUSY: if (s_fin_i) begin
                dst_acc_d = deltaw_i;
                da_d      = '0;
                // Gradient accumulation only drains on the final batch.
                state_d   = (~deltaw_i | last_i) ? DRAIN : RELEASE;
            end
            DRAIN: begin
                dst_v_o = dst_ready_i;
                if (dst_ready_i) begin
                    if (da_q == ds_i) begin
                        da_d    = '0;
                        state_d = RELEASE;
                    end else begin
                        da_d = da_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                rel     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            da_q        <= '0;
            len_err_q   <= 1'b0;
            dst_acc_q   <= 1'b0;
            dst_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            da_q      <= da_d;
            len_err_q <= len_err_d;
            dst_acc_q <= dst_acc_d;
            if (dst_ready_i) dst_valid_q <= dst_v_o;
        end
    end

    assign src_v_o     = beat;
    assign src_a_o     = sa_q;
    assign src_bank_o  = wr_ptr;
    assign exec_bank_o = rd_ptr;
    assign dst_a_o     = da_q;
    assign dst_valid_o = dst_valid_q;
    assign dst_acc_o   = dst_acc_q;
    assign full_cnt_o  = full_cnt;
    assign len_err_o   = len_err_q;

endmodule
